// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: op codes, operand-select
// encoding and the ID/EX stage-register layout.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CTL_W   = 4;

  localparam logic [CTL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [CTL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [CTL_W-1:0] ALU_SLL = 4'b0010;
  localparam logic [CTL_W-1:0] ALU_SRL = 4'b0011;
  localparam logic [CTL_W-1:0] ALU_AND = 4'b0100;
  localparam logic [CTL_W-1:0] ALU_OR  = 4'b0101;

  typedef enum logic [1:0] {
    SRC_REG   = 2'b00,
    SRC_IMM   = 2'b01,
    SRC_SHAMT = 2'b10
  } alusrc_t;

  // sel is kept as raw bits so the unused 11 encoding survives the register.
  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   rs_a;
    logic [ADDR_W-1:0]   rt_a;
    logic [ADDR_W-1:0]   rd;
    logic [DATA_W-1:0]   rs_d;
    logic [DATA_W-1:0]   rt_d;
    logic [DATA_W-1:0]   imm;
    logic [SHAMT_W-1:0]  shamt;
    logic [CTL_W-1:0]    ctl;
    logic [1:0]          sel;
    logic                rw;
  } stage_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Forwarding selector for one source operand; EX/MEM beats MEM/WB and
// register 0 is never forwarded.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int unsigned n = DATA_W,
  parameter int unsigned r = ADDR_W
) (
  input  logic [r-1:0] src_addr_i,
  input  logic [n-1:0] src_data_i,
  input  logic         exmem_regwrite_i,
  input  logic [r-1:0] exmem_rd_i,
  input  logic [n-1:0] exmem_result_i,
  input  logic         memwb_regwrite_i,
  input  logic [r-1:0] memwb_rd_i,
  input  logic [n-1:0] memwb_result_i,
  output logic [n-1:0] fwd_data_o
);

  logic nonzero;
  logic hit_ex;
  logic hit_wb;

  always_comb begin
    nonzero = (src_addr_i != '0);
    hit_ex  = exmem_regwrite_i && (exmem_rd_i == src_addr_i) && nonzero;
    hit_wb  = memwb_regwrite_i && (memwb_rd_i == src_addr_i) && nonzero;
    if (hit_ex) begin
      fwd_data_o = exmem_result_i;
    end else if (hit_wb) begin
      fwd_data_o = memwb_result_i;
    end else begin
      fwd_data_o = src_data_i;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers decoded operands, resolves forwarding and
// maps operands onto the ALU inputs. Supports stall with refresh and flush.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned n = DATA_W,
  parameter int unsigned r = ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [r-1:0] rs_addr,
  input  logic [r-1:0] rt_addr,
  input  logic [r-1:0] rd_addr_in,
  input  logic [n-1:0] rs_data,
  input  logic [n-1:0] rt_data,
  input  logic [n-1:0] imm,
  input  logic [4:0]   shamt,
  input  logic [3:0]   alucontrol_in,
  input  logic [1:0]   alusrc,
  input  logic         regwrite_in,
  input  logic         exmem_regwrite,
  input  logic [r-1:0] exmem_rd,
  input  logic [n-1:0] exmem_result,
  input  logic         memwb_regwrite,
  input  logic [r-1:0] memwb_rd,
  input  logic [n-1:0] memwb_result,
  output logic [n-1:0] srca,
  output logic [n-1:0] srcb,
  output logic [3:0]   alucontrol,
  output logic [n-1:0] store_data,
  output logic         out_valid,
  output logic         regwrite_out,
  output logic [r-1:0] rd_addr_out
);

  stage_t       stage_q;
  stage_t       stage_d;
  logic [n-1:0] fa;
  logic [n-1:0] fb;

  fwd_mux #(.n(n), .r(r)) u_fwd_rs (
    .src_addr_i       (stage_q.rs_a),
    .src_data_i       (stage_q.rs_d),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_result_i   (memwb_result),
    .fwd_data_o       (fa)
  );

  fwd_mux #(.n(n), .r(r)) u_fwd_rt (
    .src_addr_i       (stage_q.rt_a),
    .src_data_i       (stage_q.rt_d),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_result_i   (memwb_result),
    .fwd_data_o       (fb)
  );

  // On stall the forwarded values are written back unconditionally: with no
  // hit they equal the held data, so this is the same as refresh-on-hit.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d     = '0;
      stage_d.ctl = ALU_ADD;
    end else if (stall) begin
      stage_d.rs_d = fa;
      stage_d.rt_d = fb;
    end else begin
      stage_d.valid = in_valid;
      stage_d.rs_a  = rs_addr;
      stage_d.rt_a  = rt_addr;
      stage_d.rd    = rd_addr_in;
      stage_d.rs_d  = rs_data;
      stage_d.rt_d  = rt_data;
      stage_d.imm   = imm;
      stage_d.shamt = shamt;
      stage_d.ctl   = alucontrol_in;
      stage_d.sel   = alusrc;
      stage_d.rw    = regwrite_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    srca = fa;
    srcb = fb;
    case (alusrc_t'(stage_q.sel))
      SRC_IMM: begin
        srca = fa;
        srcb = stage_q.imm;
      end
      SRC_SHAMT: begin
        srca = fb;
        srcb = {{(n - SHAMT_W){1'b0}}, stage_q.shamt};
      end
      default: begin
        srca = fa;
        srcb = fb;
      end
    endcase
  end

  assign store_data   = fb;
  assign alucontrol   = stage_q.ctl;
  assign out_valid    = stage_q.valid;
  assign regwrite_out = stage_q.rw && stage_q.valid;
  assign rd_addr_out  = stage_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, stall/flush
// and reset sequences, then random traffic against a behavioural model.
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int N = 32;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         reset, stall, flush, in_valid;
  logic [R-1:0] rs_addr, rt_addr, rd_addr_in;
  logic [N-1:0] rs_data, rt_data, imm;
  logic [4:0]   shamt;
  logic [3:0]   alucontrol_in;
  logic [1:0]   alusrc;
  logic         regwrite_in;
  logic         exmem_regwrite, memwb_regwrite;
  logic [R-1:0] exmem_rd, memwb_rd;
  logic [N-1:0] exmem_result, memwb_result;
  logic [N-1:0] srca, srcb, store_data;
  logic [3:0]   alucontrol;
  logic         out_valid, regwrite_out;
  logic [R-1:0] rd_addr_out;

  alu_operand_stage #(.n(N), .r(R)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr_in(rd_addr_in),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .shamt(shamt),
    .alucontrol_in(alucontrol_in), .alusrc(alusrc), .regwrite_in(regwrite_in),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .store_data(store_data),
    .out_valid(out_valid), .regwrite_out(regwrite_out), .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of the instruction currently held in the stage.
  bit        m_valid, m_rw;
  bit [4:0]  m_rs_a, m_rt_a, m_rd, m_shamt;
  bit [31:0] m_rs_d, m_rt_d, m_imm;
  bit [3:0]  m_ctl;
  bit [1:0]  m_sel;

  function automatic bit [31:0] fwd(input bit [4:0] a, input bit [31:0] d);
    if (a != 0 && exmem_regwrite && exmem_rd == a) return exmem_result;
    if (a != 0 && memwb_regwrite && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_rs_a = 0; m_rt_a = 0; m_rd = 0; m_shamt = 0;
    m_rs_d = 0; m_rt_d = 0; m_imm = 0; m_ctl = 0; m_sel = 0;
  endtask

  task automatic check_model(input string tag);
    bit [31:0] a, b, ea, eb;
    a = fwd(m_rs_a, m_rs_d);
    b = fwd(m_rt_a, m_rt_d);
    if (m_sel == 2'b01)      begin ea = a; eb = m_imm; end
    else if (m_sel == 2'b10) begin ea = b; eb = 32'(m_shamt); end
    else                     begin ea = a; eb = b; end
    cmp({tag, " srca"}, srca, ea);
    cmp({tag, " srcb"}, srcb, eb);
    cmp({tag, " store"}, store_data, b);
    cmp({tag, " ctl"}, 32'(alucontrol), 32'(m_ctl));
    cmp({tag, " valid"}, 32'(out_valid), 32'(m_valid));
    cmp({tag, " rw"}, 32'(regwrite_out), 32'(m_rw & m_valid));
    cmp({tag, " rd"}, 32'(rd_addr_out), 32'(m_rd));
  endtask

  // Advances one clock; model next state is taken from the inputs seen before the edge.
  task automatic tick();
    bit [31:0] nrs, nrt;
    bit        do_flush, do_stall;
    nrs = fwd(m_rs_a, m_rs_d);
    nrt = fwd(m_rt_a, m_rt_d);
    do_flush = flush;
    do_stall = stall;
    @(posedge clk);
    #1;
    if (reset || do_flush) model_clear();
    else if (do_stall) begin
      m_rs_d = nrs;
      m_rt_d = nrt;
    end else begin
      m_valid = in_valid; m_rs_a = rs_addr; m_rt_a = rt_addr; m_rd = rd_addr_in;
      m_rs_d = rs_data; m_rt_d = rt_data; m_imm = imm; m_shamt = shamt;
      m_ctl = alucontrol_in; m_sel = alusrc; m_rw = regwrite_in;
    end
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; in_valid = 0; rs_addr = 0; rt_addr = 0; rd_addr_in = 0;
    rs_data = 0; rt_data = 0; imm = 0; shamt = 0; alucontrol_in = 0; alusrc = 0;
    regwrite_in = 0; exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  typedef struct {
    bit        valid;
    bit [4:0]  rs_a, rt_a, rd;
    bit [31:0] rs_d, rt_d, imm;
    bit [4:0]  shamt;
    bit [3:0]  ctl;
    bit [1:0]  sel;
    bit        rw;
    bit        ex_rw;
    bit [4:0]  ex_rd;
    bit [31:0] ex_res;
    bit        wb_rw;
    bit [4:0]  wb_rd;
    bit [31:0] wb_res;
    bit [31:0] e_srca, e_srcb, e_store;
    bit [3:0]  e_ctl;
    bit        e_ov, e_rwo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    model_clear();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    cmp("reset srca", srca, 0);
    cmp("reset srcb", srcb, 0);
    cmp("reset ctl", 32'(alucontrol), 0);
    cmp("reset valid", 32'(out_valid), 0);
    cmp("reset rw", 32'(regwrite_out), 0);
    reset = 0;

    // valid rs rt rd rs_d rt_d imm shamt ctl sel rw | ex | wb | srca srcb store ctl ov rwo
    vecs[0] = '{1, 1, 2, 3, 10, 3, 0, 0, ALU_SUB, 0, 1, 0, 0, 0, 0, 0, 0, 10, 3, 3, ALU_SUB, 1, 1};
    vecs[1] = '{1, 8, 9, 4, 1, 2, 0, 0, ALU_ADD, 0, 1, 1, 8, 'hAA, 1, 8, 'hBB, 'hAA, 2, 2, ALU_ADD, 1, 1};
    vecs[2] = '{1, 8, 9, 4, 1, 2, 0, 0, ALU_ADD, 0, 1, 0, 8, 'hAA, 1, 8, 'hBB, 'hBB, 2, 2, ALU_ADD, 1, 1};
    vecs[3] = '{1, 0, 1, 5, 'h12, 6, 0, 0, ALU_OR, 0, 0, 1, 0, 'hFF, 1, 0, 'hEE, 'h12, 6, 6, ALU_OR, 1, 0};
    vecs[4] = '{1, 7, 3, 6, 'h9, 1, 0, 4, ALU_SLL, 2, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1, ALU_SLL, 1, 1};
    vecs[5] = '{1, 4, 5, 2, 'h20, 7, 'hFFFF_FFF0, 9, ALU_AND, 1, 1, 0, 0, 0, 1, 5, 'h77, 'h20, 'hFFFF_FFF0, 'h77, ALU_AND, 1, 1};
    vecs[6] = '{1, 2, 4, 1, 3, 9, 'h5, 1, ALU_SRL, 3, 1, 1, 4, 'h44, 0, 0, 0, 3, 'h44, 'h44, ALU_SRL, 1, 1};
    vecs[7] = '{0, 1, 2, 31, 'h11, 'h22, 0, 0, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0, 'h11, 'h22, 'h22, 4'hF, 0, 0};

    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      in_valid = vecs[i].valid; rs_addr = vecs[i].rs_a; rt_addr = vecs[i].rt_a;
      rd_addr_in = vecs[i].rd; rs_data = vecs[i].rs_d; rt_data = vecs[i].rt_d;
      imm = vecs[i].imm; shamt = vecs[i].shamt; alucontrol_in = vecs[i].ctl;
      alusrc = vecs[i].sel; regwrite_in = vecs[i].rw;
      tick();
      exmem_regwrite = vecs[i].ex_rw; exmem_rd = vecs[i].ex_rd; exmem_result = vecs[i].ex_res;
      memwb_regwrite = vecs[i].wb_rw; memwb_rd = vecs[i].wb_rd; memwb_result = vecs[i].wb_res;
      #1;
      cmp($sformatf("v%0d srca", i), srca, vecs[i].e_srca);
      cmp($sformatf("v%0d srcb", i), srcb, vecs[i].e_srcb);
      cmp($sformatf("v%0d store", i), store_data, vecs[i].e_store);
      cmp($sformatf("v%0d ctl", i), 32'(alucontrol), 32'(vecs[i].e_ctl));
      cmp($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      cmp($sformatf("v%0d rw", i), 32'(regwrite_out), 32'(vecs[i].e_rwo));
      cmp($sformatf("v%0d rd", i), 32'(rd_addr_out), 32'(vecs[i].rd));
    end

    // Stall with a one-cycle MEM/WB refresh, then flush together with stall.
    clear_inputs();
    in_valid = 1; rs_addr = 0; rs_data = 3; rt_addr = 6; rt_data = 'h11;
    rd_addr_in = 7; alucontrol_in = ALU_SUB; regwrite_in = 1;
    tick();
    cmp("pre-stall srcb", srcb, 'h11);
    stall = 1; memwb_regwrite = 1; memwb_rd = 6; memwb_result = 'h55;
    rt_data = 'h99; alucontrol_in = 4'hF; in_valid = 0;
    #1;
    cmp("stall c1 srcb", srcb, 'h55);
    tick();
    memwb_regwrite = 0; memwb_result = 0;
    #1;
    cmp("stall c2 srcb", srcb, 'h55);
    cmp("stall c2 store", store_data, 'h55);
    cmp("stall c2 ctl", 32'(alucontrol), 32'(ALU_SUB));
    cmp("stall c2 valid", 32'(out_valid), 1);
    flush = 1;
    tick();
    cmp("flush valid", 32'(out_valid), 0);
    cmp("flush rw", 32'(regwrite_out), 0);
    cmp("flush ctl", 32'(alucontrol), 0);
    cmp("flush srcb", srcb, 0);

    // Asynchronous reset between edges.
    clear_inputs();
    in_valid = 1; rs_addr = 1; rt_addr = 2; rs_data = 5; rt_data = 7;
    alucontrol_in = ALU_ADD; regwrite_in = 1; rd_addr_in = 3;
    tick();
    cmp("pre-reset srca", srca, 5);
    cmp("pre-reset srcb", srcb, 7);
    #2;
    reset = 1;
    #1;
    cmp("async reset srca", srca, 0);
    cmp("async reset srcb", srcb, 0);
    cmp("async reset valid", 32'(out_valid), 0);
    cmp("async reset rw", 32'(regwrite_out), 0);
    model_clear();
    @(negedge clk);
    reset = 0;

    // Random traffic with a small register range so hits are frequent.
    for (int k = 0; k < 300; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      in_valid = 1'($urandom);
      rs_addr = 5'($urandom_range(0, 3));
      rt_addr = 5'($urandom_range(0, 3));
      rd_addr_in = 5'($urandom);
      rs_data = $urandom; rt_data = $urandom; imm = $urandom;
      shamt = 5'($urandom); alucontrol_in = 4'($urandom);
      alusrc = 2'($urandom); regwrite_in = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      #1;
      check_model($sformatf("r%0d", k));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
